// File: rtl/bias_fetcher.sv
// Bias ROM read sequencer: issues one layer's worth of sequential ROM reads,
// captures each returning word into a small FIFO and streams it out as
// valid/ready beats tagged with the channel index. A read is only issued when
// the FIFO is guaranteed to have room for it, so backpressure never drops data.
module bias_fetcher #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_channels,
    output logic              rom_read_enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_bias_out,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic [WIDTH-1:0]  bias_data,
    output logic [CNT_W-1:0]  bias_channel,
    output logic              bias_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic              cap_q;        // a read was issued last cycle; ROM data is present now
    logic [CNT_W-1:0]  cap_ch_q;     // channel index of the word being captured

    logic [WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [CNT_W-1:0]  fifo_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;

    logic              issue;
    logic              last_issue;
    logic              pop;
    logic [ADDR_W:0]   addr_sum;
    logic [CNT_W-1:0]  head_ch;

    // Issue decision, address generation and stream outputs.
    always_comb begin
        // Count the in-flight read as occupied space so its word always fits.
        issue      = (state_q == StIssue) &&
                     ((32'(count_q) + 32'(cap_q)) < FIFO_DEPTH);
        last_issue = issue && (issue_cnt_q == num_q - CNT_W'(1));

        addr_sum        = {1'b0, base_q} + (ADDR_W + 1)'(issue_cnt_q);
        rom_read_enable = issue;
        rom_addr        = '0;
        if (issue) begin
            rom_addr = ADDR_W'((addr_sum >= (ADDR_W + 1)'(DEPTH)) ?
                               (addr_sum - (ADDR_W + 1)'(DEPTH)) : addr_sum);
        end

        head_ch      = fifo_ch[rd_ptr_q];
        bias_valid   = (count_q != '0);
        bias_data    = bias_valid ? fifo_data[rd_ptr_q] : '0;
        bias_channel = bias_valid ? head_ch : '0;
        bias_last    = bias_valid && (head_ch == num_q - CNT_W'(1));
        pop          = bias_valid && bias_ready;

        busy = (state_q == StIssue) || (state_q == StDrain);
        done = (state_q == StDone);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_channels == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && bias_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer parameters, issue counter and capture flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            num_q       <= '0;
            issue_cnt_q <= '0;
            cap_q       <= 1'b0;
            cap_ch_q    <= '0;
        end else begin
            if ((state_q == StIdle) && start) begin
                base_q      <= base_addr;
                num_q       <= num_channels;
                issue_cnt_q <= '0;
            end else if (issue) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            cap_q <= issue;
            if (issue) begin
                cap_ch_q <= issue_cnt_q;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous capture and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (cap_q) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (cap_q && !pop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!cap_q && pop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (cap_q) begin
            fifo_data[wr_ptr_q] <= rom_bias_out;
            fifo_ch[wr_ptr_q]   <= cap_ch_q;
        end
    end

endmodule

// File: doc/bias_fetcher.md
# bias_fetcher

Read-side sequencer for the per-layer bias ROM. On a start pulse it issues sequential reads for one layer's channels starting at a base address. It captures each word one cycle after issue, buffers it in a small FIFO and presents it as a valid/ready stream to the accumulator/requantisation stage. A read is issued only when FIFO space is guaranteed, so backpressure never drops a ROM word.

## Interface
- WIDTH, 32, bias word width; must match the ROM.
- DEPTH, 256, ROM depth in words; ADDR_W = $clog2(DEPTH).
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of channel count and index.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  ROM address of channel 0 for the layer; sampled with start.
- num_channels  in  CNT_W  channel count, 0..DEPTH; sampled with start.
- rom_read_enable  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM read address.
- rom_bias_out  in  WIDTH  ROM data, valid the cycle after rom_read_enable. The ROM drives 0 otherwise.
- bias_valid  out  1  FIFO head valid.
- bias_ready  in  1  consumer accepts the head.
- bias_data  out  WIDTH  head word; 0 when bias_valid=0.
- bias_channel  out  CNT_W  channel index of the head word.
- bias_last  out  1  head is channel num_channels-1.
- busy  out  1  a layer fetch is in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States:
  - IDLE: waiting for start.
  - ISSUE: reads still to be issued.
  - DRAIN: all reads issued, FIFO and in-flight read not yet empty.
  - DONE: one cycle, done=1.
- IDLE to ISSUE: on start with num_channels≥1. The block latches base_addr and num_channels and clears issue_cnt and out_cnt.
- IDLE to DONE: on start with num_channels=0. No ROM read is issued and no beat is produced.
- start outside IDLE is ignored; the latched parameters are unchanged.
- Issue rule in ISSUE:
  - rom_read_enable=1 iff fifo_count + inflight < FIFO_DEPTH, where inflight is 1 if a read was issued in the previous cycle.
  - rom_addr = (base_addr + issue_cnt) mod DEPTH. The address wraps at DEPTH with no error.
  - issue_cnt increments on each issue.
- ISSUE to DRAIN: on the cycle the read for issue_cnt = num_channels-1 is issued.
- Capture: a registered flag, set in the cycle after an issue, writes rom_bias_out into the FIFO. No other cycle writes the FIFO, so the ROM's zero output is never captured.
- FIFO tags:
  - Each entry carries its channel index (capture order).
  - bias_last is derived as index == num_channels-1.
- Handshake:
  - A beat transfers when bias_valid && bias_ready; out_cnt increments.
  - bias_valid does not drop without a transfer, and bias_data/bias_channel are stable while valid and not ready.
  - Capture and pop in the same cycle are legal; count is unchanged.
- DRAIN to DONE: on the transfer with bias_last=1.
- DONE to IDLE: unconditionally the next cycle.
- busy = 1 in ISSUE and DRAIN; busy = 0 in IDLE and DONE.
- reset:
  - All outputs 0; state IDLE; FIFO flushed; counters and capture flag cleared.
  - Reset mid-operation abandons the layer. Any ROM word returning the next cycle is discarded, and no done pulse is produced.

## Timing
- Let start be sampled at edge E0 (cycle 0).
- Cycle 1: first rom_read_enable=1 with rom_addr=base_addr.
- Cycle 2: ROM data present; written to the FIFO at the end of cycle 2.
- Cycle 3: first bias_valid=1. The start-to-first-beat latency is 3 cycles.
- With bias_ready held 1, the block sustains one read and one beat per cycle. The last beat is at cycle num_channels+2 and done at cycle num_channels+3.
- With bias_ready=0, issue stops once fifo_count+inflight reaches FIFO_DEPTH. At most FIFO_DEPTH words are buffered and none is lost.
- num_channels=0: done=1 in cycle 1; rom_read_enable stays 0 throughout.

## Test plan
- Basic stream:
  - Stimulus: base=0x10, n=5, ready=1, ROM[k]=k*3.
  - Required: reads at addresses 0x10..0x14 in cycles 1..5; beats 0x30,0x33,0x36,0x39,0x3C with channels 0..4 in cycles 3..7; bias_last only on channel 4; done in cycle 8.
- Backpressure:
  - Stimulus: n=10, FIFO_DEPTH=4, ready=0 for 20 cycles, then 1.
  - Required: exactly 4 reads issued during the stall; then all 10 beats arrive in order with no gaps, duplicates or zero words.
- Random ready:
  - Stimulus: n=DEPTH, 50% random ready.
  - Required: every beat matches ROM[(base+i) mod DEPTH]; bias_data is stable while stalled; exactly one done.
- Wrap-around:
  - Stimulus: base=DEPTH-2, n=4.
  - Required: addresses DEPTH-2, DEPTH-1, 0, 1.
- Zero and ignored start:
  - Stimulus: n=0.
  - Required: done in cycle 1, no reads, no beats.
  - Stimulus: second start mid-fetch.
  - Required: the second start has no effect.
- Reset mid-fetch:
  - Stimulus: assert reset one cycle after a read is issued.
  - Required: all outputs 0 next cycle; the returning ROM word is not captured; a new start then produces a correct stream from channel 0.
